// File: rtl/crc8_pkg.sv
// Shared definitions for the byte-stream CRC-8 engine: state encoding,
// CRC width and an 8-bit bit-reverse helper used by reflected variants.
package crc8_pkg;

  localparam int CRC_W = 8;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    WAIT   = 2'd1,
    DONE   = 2'd2
  } crc_state_e;

  function automatic logic [CRC_W-1:0] bitrev8(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    r = '0;
    for (int i = 0; i < CRC_W; i++) begin
      r[i] = v[CRC_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc8_stream.sv
// Table-driven CRC-8 over a framed byte stream; the lookup ROM sits outside.
// Define CRC8_STREAM_REFIN_EN for reflected-input/output variants.
module crc8_stream
  import crc8_pkg::*;
#(
  parameter logic [CRC_W-1:0] INIT    = 8'h00,
  parameter logic [CRC_W-1:0] XOR_OUT = 8'h00
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CRC_W-1:0] data_i,
  input  logic             valid_i,
  input  logic             last_i,
  output logic             ready_o,
  output logic [CRC_W-1:0] tbl_addr_o,
  input  logic [CRC_W-1:0] tbl_value_i,
  output logic [CRC_W-1:0] crc_o,
  output logic             crc_valid_o,
  input  logic             crc_ready_i,
  output logic [1:0]       dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; the producer holds its payload until that edge.

  crc_state_e       r_state;
  crc_state_e       w_next_state;
  logic [CRC_W-1:0] r_crc;
  logic             r_last;
  logic [CRC_W-1:0] w_data;
  logic [CRC_W-1:0] w_crc_view;

  always_comb begin
`ifdef CRC8_STREAM_REFIN_EN
    w_data     = bitrev8(data_i);
    w_crc_view = bitrev8(r_crc);
`else
    w_data     = data_i;
    w_crc_view = r_crc;
`endif
  end

  // The address is driven in every state; the ROM read only matters on
  // the ACCEPT handshake edge.
  assign tbl_addr_o  = r_crc ^ w_data;
  assign crc_o       = w_crc_view ^ XOR_OUT;
  assign ready_o     = (r_state == ACCEPT);
  assign crc_valid_o = (r_state == DONE);
  assign dbg_state_o = r_state;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ACCEPT:  if (valid_i) w_next_state = WAIT;
      WAIT:    w_next_state = r_last ? DONE : ACCEPT;
      DONE:    if (crc_ready_i) w_next_state = ACCEPT;
      default: w_next_state = ACCEPT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ACCEPT;
      r_crc   <= INIT;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ACCEPT:  if (valid_i) r_last <= last_i;
        WAIT:    r_crc <= tbl_value_i;
        DONE:    if (crc_ready_i) r_crc <= INIT;
        default: r_crc <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_crc8_stream.sv
// Directed bench for crc8_stream with a registered CRC-8 (poly 0x07) ROM model.
module tb_crc8_stream;
  import crc8_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       ready;
  logic [7:0] tbl_addr;
  logic [7:0] tbl_value;
  logic [7:0] crc;
  logic       crc_valid;
  logic       crc_ready;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  crc8_stream dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .data_i      (data),
    .valid_i     (valid),
    .last_i      (last),
    .ready_o     (ready),
    .tbl_addr_o  (tbl_addr),
    .tbl_value_i (tbl_value),
    .crc_o       (crc),
    .crc_valid_o (crc_valid),
    .crc_ready_i (crc_ready),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- ROM model ----------------
  function automatic logic [7:0] rom_entry(input logic [7:0] idx);
    logic [7:0] c;
    c = idx;
    for (int b = 0; b < 8; b++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  always @(posedge clk) tbl_value <= rom_entry(tbl_addr);

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst_n = 1'b0; valid = 1'b0; last = 1'b0; data = 8'h00; crc_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Offers one byte and returns one step after its handshake edge.
  task automatic send_byte(input logic [7:0] b, input logic l, output bit ok);
    ok = 1'b0;
    data = b; last = l; valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output bit ok);
    cycles = 0; ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (crc_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic release_crc();
    crc_ready = 1'b1;
    @(posedge clk);
    #1;
    crc_ready = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    data = 8'h5A;
    #1;
    n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", ready); end
    n_vec++; if (crc_valid !== 1'b0) begin n_err++; $display("FAIL reset_crc_valid got=%b exp=0", crc_valid); end
    n_vec++; if (crc !== 8'h00) begin n_err++; $display("FAIL reset_crc got=%h exp=00", crc); end
    n_vec++; if (tbl_addr !== 8'h5A) begin n_err++; $display("FAIL reset_tbl_addr got=%h exp=5a", tbl_addr); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_single_byte();
    bit ok; int cyc;
    send_byte(8'h01, 1'b1, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_hs got=timeout exp=handshake"); end
    n_vec++; if (crc_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_early got=%b exp=0", crc_valid); end
    wait_done(cyc, ok);
    n_vec++; if (!ok || cyc != 1) begin n_err++; $display("FAIL single_latency got=%0d ok=%0d exp=1", cyc, ok); end
    n_vec++; if (crc !== 8'h07) begin n_err++; $display("FAIL single_crc got=%h exp=07", crc); end
    release_crc();
  endtask

  task automatic test_two_bytes();
    logic [7:0] bytes [2];
    logic       rdy [4];
    logic       exp_rdy [4];
    int idx; bit hs;
    bytes[0] = 8'h01; bytes[1] = 8'h02;
    exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b0; exp_rdy[2] = 1'b1; exp_rdy[3] = 1'b0;
    idx = 0; data = bytes[0]; last = 1'b0; valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rdy[k] = ready;
      if (k == 2) begin
        n_vec++; if (tbl_addr !== 8'h05) begin n_err++; $display("FAIL two_tbl_addr got=%h exp=05", tbl_addr); end
      end
      hs = ready & valid;
      @(posedge clk);
      #1;
      if (hs) begin
        idx++;
        if (idx == 2) valid = 1'b0;
        else begin data = bytes[idx]; last = (idx == 1); end
      end
    end
    valid = 1'b0; last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (rdy[k] !== exp_rdy[k]) begin n_err++; $display("FAIL two_ready[%0d] got=%b exp=%b", k, rdy[k], exp_rdy[k]); end
    end
    n_vec++; if (crc_valid !== 1'b1) begin n_err++; $display("FAIL two_valid got=%b exp=1", crc_valid); end
    n_vec++; if (crc !== 8'h1B) begin n_err++; $display("FAIL two_crc got=%h exp=1b", crc); end
    release_crc();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [9];
    int idx; int cyc; bit hs;
    for (int k = 0; k < 9; k++) bytes[k] = 8'h31 + 8'(k);
    idx = 0; cyc = 0; data = bytes[0]; last = 1'b0; valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      hs = ready & valid;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) begin
        idx++;
        if (idx == 9) begin valid = 1'b0; last = 1'b0; end
        else begin data = bytes[idx]; last = (idx == 8); end
      end
      if (crc_valid) break;
    end
    valid = 1'b0; last = 1'b0;
    n_vec++; if (idx != 9) begin n_err++; $display("FAIL b2b_bytes got=%0d exp=9", idx); end
    n_vec++; if (cyc != 18) begin n_err++; $display("FAIL b2b_cycles got=%0d exp=18", cyc); end
    n_vec++; if (crc !== 8'hF4) begin n_err++; $display("FAIL b2b_crc got=%h exp=f4", crc); end
    release_crc();
  endtask

  task automatic test_hold_and_init();
    bit ok; int cyc;
    send_byte(8'h01, 1'b1, ok);
    wait_done(cyc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL hold_done got=timeout exp=crc_valid"); end
    valid = 1'b1; data = 8'h55; last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      n_vec++; if (crc !== 8'h07 || crc_valid !== 1'b1 || ready !== 1'b0) begin
        n_err++; $display("FAIL hold[%0d] got crc=%h v=%b rdy=%b exp crc=07 v=1 rdy=0", k, crc, crc_valid, ready);
      end
    end
    valid = 1'b0; last = 1'b0;
    release_crc();
    n_vec++; if (ready !== 1'b1 || crc_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_release got rdy=%b v=%b exp rdy=1 v=0", ready, crc_valid);
    end
    send_byte(8'h00, 1'b1, ok);
    wait_done(cyc, ok);
    n_vec++; if (!ok || crc !== 8'h00) begin n_err++; $display("FAIL init_restore got=%h ok=%0d exp=00", crc, ok); end
    release_crc();
  endtask

  task automatic test_reset_mid_frame();
    bit ok; int cyc;
    send_byte(8'h31, 1'b0, ok);
    send_byte(8'h32, 1'b0, ok);
    send_byte(8'h33, 1'b0, ok);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    data = 8'h00;
    #1;
    n_vec++; if (ready !== 1'b1 || crc_valid !== 1'b0 || crc !== 8'h00 || tbl_addr !== 8'h00) begin
      n_err++; $display("FAIL midreset got rdy=%b v=%b crc=%h addr=%h exp rdy=1 v=0 crc=00 addr=00", ready, crc_valid, crc, tbl_addr);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      n_vec++; if (crc_valid !== 1'b0) begin n_err++; $display("FAIL midreset_no_emit got=%b exp=0", crc_valid); end
    end
    send_byte(8'h01, 1'b1, ok);
    wait_done(cyc, ok);
    n_vec++; if (!ok || crc !== 8'h07) begin n_err++; $display("FAIL midreset_next got=%h ok=%0d exp=07", crc, ok); end
    release_crc();
  endtask

  task automatic test_refin();
    bit ok; int cyc;
    send_byte(8'h80, 1'b1, ok);
    wait_done(cyc, ok);
    n_vec++; if (!ok || crc !== 8'hE0) begin n_err++; $display("FAIL refin_crc got=%h ok=%0d exp=e0", crc, ok); end
    release_crc();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    apply_reset();
    test_reset();
`ifdef CRC8_STREAM_REFIN_EN
    test_refin();
`else
    test_single_byte();
    test_two_bytes();
    test_back_to_back();
    test_hold_and_init();
    test_reset_mid_frame();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
